// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the decimal-conversion stages:
//   state_t  - accumulator FSM states
//   BCD_MAX  - largest legal BCD digit code
//   is_bcd() - returns 1 when a 4-bit code is a legal decimal digit (0..9)
// ---------------------------------------------------------------------------
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_ERR  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bcd(input logic [3:0] digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

// File: rtl/mul10_add.sv
// ---------------------------------------------------------------------------
// mul10_add
// Combinational acc*10 + digit, built from shifts and adds so that no
// multiplier is needed.
// Ports:
//   i_acc   [OUT_W-1:0] running binary value
//   i_digit [3:0]       decimal digit appended at the least significant end
//   o_sum   [OUT_W-1:0] i_acc*10 + i_digit, truncated to OUT_W bits
// The caller guarantees the result fits in OUT_W bits.
// ---------------------------------------------------------------------------
module mul10_add #(
   parameter int OUT_W = 10
) (
   input  logic [OUT_W-1:0] i_acc,
   input  logic [3:0]       i_digit,
   output logic [OUT_W-1:0] o_sum
);

   logic [OUT_W-1:0] w_digit_ext;

   assign w_digit_ext = {{(OUT_W-4){1'b0}}, i_digit};

   // x*10 = x*8 + x*2
   assign o_sum = (i_acc << 3) + (i_acc << 1) + w_digit_ext;

endmodule

// File: rtl/bcd_digit_accumulator.sv
// ---------------------------------------------------------------------------
// bcd_digit_accumulator
// Accumulates a most-significant-first stream of BCD digits into a binary
// number (value = value*10 + digit) and presents it on a registered
// valid/ready output. Any illegal digit code (10..15) in a number turns the
// result into an error (bin_err=1, bin_out=0).
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   digit_in     in   [3:0] BCD digit
//   digit_valid  in   digit_in valid
//   digit_last   in   digit is the final one of the number
//   digit_ready  out  digit accepted this cycle (decoded from state only)
//   bin_out      out  [OUT_W-1:0] accumulated binary result
//   bin_err      out  result invalid (illegal digit seen)
//   out_valid    out  bin_out/bin_err valid
//   out_ready    in   downstream consumes the result
// ---------------------------------------------------------------------------
module bcd_digit_accumulator
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int OUT_W      = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       digit_in,
   input  logic             digit_valid,
   input  logic             digit_last,
   output logic             digit_ready,
   output logic [OUT_W-1:0] bin_out,
   output logic             bin_err,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);

   state_t           r_state;
   logic [OUT_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [OUT_W-1:0] r_bin_out;
   logic             r_bin_err;
   logic             r_out_valid;

   logic             w_xfer;
   logic             w_legal;
   logic             w_term;
   logic [CNT_W-1:0] w_cnt_next;
   logic [OUT_W-1:0] w_acc_in;
   logic [OUT_W-1:0] w_sum;

   // Ready depends on state alone so there is no path from digit_valid.
   assign digit_ready = (r_state != S_DONE);

   assign w_xfer     = digit_valid && digit_ready;
   assign w_legal    = is_bcd(digit_in);
   assign w_cnt_next = r_cnt + CNT_W'(1);
   // The first digit of a number starts from zero regardless of r_acc.
   assign w_acc_in   = (r_state == S_IDLE) ? '0 : r_acc;
   // Termination on the explicit last flag or on reaching the digit limit.
   assign w_term     = digit_last || (w_cnt_next == CNT_MAX);

   mul10_add #(
      .OUT_W (OUT_W)
   ) u_mul10_add (
      .i_acc   (w_acc_in),
      .i_digit (digit_in),
      .o_sum   (w_sum)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_bin_out   <= '0;
         r_bin_err   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_ACC: begin
               if (w_xfer) begin
                  r_cnt <= w_cnt_next;
                  if (w_legal) begin
                     r_acc <= w_sum;
                  end
                  if (w_term) begin
                     // An illegal terminating digit reports the error directly.
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_bin_err   <= !w_legal;
                     r_bin_out   <= w_legal ? w_sum : '0;
                  end else begin
                     r_state <= w_legal ? S_ACC : S_ERR;
                  end
               end
            end
            S_ERR: begin
               // Digits are swallowed but still counted toward the limit.
               if (w_xfer) begin
                  r_cnt <= w_cnt_next;
                  if (w_term) begin
                     r_state     <= S_DONE;
                     r_out_valid <= 1'b1;
                     r_bin_err   <= 1'b1;
                     r_bin_out   <= '0;
                  end
               end
            end
            S_DONE: begin
               // bin_out/bin_err keep their values after the handshake.
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_acc       <= '0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bin_out   = r_bin_out;
   assign bin_err   = r_bin_err;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_accumulator
// Directed bench for bcd_digit_accumulator (NUM_DIGITS=3, OUT_W=10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_digit_accumulator;

   localparam int NUM_DIGITS = 3;
   localparam int OUT_W      = 10;

   logic             clk;
   logic             reset;
   logic [3:0]       digit_in;
   logic             digit_valid;
   logic             digit_last;
   logic             digit_ready;
   logic [OUT_W-1:0] bin_out;
   logic             bin_err;
   logic             out_valid;
   logic             out_ready;

   int n_checks;
   int n_fail;

   bcd_digit_accumulator #(
      .NUM_DIGITS (NUM_DIGITS),
      .OUT_W      (OUT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .digit_last  (digit_last),
      .digit_ready (digit_ready),
      .bin_out     (bin_out),
      .bin_err     (bin_err),
      .out_valid   (out_valid),
      .out_ready   (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one digit for one clock and return on the following falling edge.
   task automatic send(input logic [3:0] d, input logic last);
      digit_in    = d;
      digit_valid = 1'b1;
      digit_last  = last;
      @(posedge clk);
      @(negedge clk);
      digit_valid = 1'b0;
      digit_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [31:0] val, input logic err);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_bin"}, {22'd0, bin_out}, val);
      check({tag, "_err"}, {31'd0, bin_err}, {31'd0, err});
      check({tag, "_ready"}, {31'd0, digit_ready}, 32'd0);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b0;
      digit_in    = 4'd9;
      digit_valid = 1'b1;
      digit_last  = 1'b0;
      out_ready   = 1'b1;

      // Reset held for 3 cycles with a digit offered
      repeat (3) @(negedge clk);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_bin", {22'd0, bin_out}, 32'd0);
      check("rst_ready", {31'd0, digit_ready}, 32'd1);
      digit_valid = 1'b0;
      reset       = 1'b1;
      @(negedge clk);
      check("rst_idle_valid", {31'd0, out_valid}, 32'd0);

      // Full 3-digit number terminated by count
      send(4'd9, 1'b0);
      check("full_mid_valid", {31'd0, out_valid}, 32'd0);
      send(4'd8, 1'b0);
      send(4'd7, 1'b0);
      check_result("full", 32'd987, 1'b0);
      @(negedge clk);
      check("full_after_valid", {31'd0, out_valid}, 32'd0);
      check("full_after_ready", {31'd0, digit_ready}, 32'd1);

      // Early termination, then a single-digit number
      send(4'd4, 1'b0);
      send(4'd2, 1'b1);
      check_result("early", 32'd42, 1'b0);
      @(negedge clk);
      send(4'd5, 1'b1);
      check_result("single", 32'd5, 1'b0);
      @(negedge clk);

      // Illegal digit in the middle
      send(4'd1, 1'b0);
      send(4'hF, 1'b0);
      check("illegal_mid_valid", {31'd0, out_valid}, 32'd0);
      send(4'd3, 1'b0);
      check_result("illegal", 32'd0, 1'b1);
      @(negedge clk);

      // Recovery with leading zeros; a stray last without valid is ignored
      send(4'd0, 1'b0);
      digit_last = 1'b1;
      @(negedge clk);
      digit_last = 1'b0;
      check("stray_last_valid", {31'd0, out_valid}, 32'd0);
      send(4'd0, 1'b0);
      send(4'd1, 1'b0);
      check_result("recover", 32'd1, 1'b0);
      @(negedge clk);

      // Illegal digit that is itself the terminating digit
      send(4'd2, 1'b0);
      send(4'hC, 1'b1);
      check_result("illegal_last", 32'd0, 1'b1);
      @(negedge clk);

      // Back-pressure: result held while out_ready is low, extra digit offered
      out_ready = 1'b0;
      send(4'd1, 1'b0);
      send(4'd2, 1'b0);
      send(4'd3, 1'b0);
      digit_in    = 4'd9;
      digit_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_result("bp", 32'd123, 1'b0);
         @(negedge clk);
      end
      digit_valid = 1'b0;
      out_ready   = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_ready", {31'd0, digit_ready}, 32'd1);
      check("bp_release_bin_hold", {22'd0, bin_out}, 32'd123);

      // Reset in the middle of a number
      send(4'd5, 1'b0);
      send(4'd6, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_ready", {31'd0, digit_ready}, 32'd1);
      reset = 1'b1;
      out_ready = 1'b0;
      send(4'd7, 1'b0);
      send(4'd8, 1'b0);
      send(4'd9, 1'b0);
      check_result("midrst", 32'd789, 1'b0);

      // Reset while a result is pending drops out_valid without a clock edge
      reset = 1'b0;
      #1;
      check("done_rst_valid", {31'd0, out_valid}, 32'd0);
      check("done_rst_bin", {22'd0, bin_out}, 32'd0);
      check("done_rst_ready", {31'd0, digit_ready}, 32'd1);
      @(negedge clk);
      reset     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_digit_accumulator.md
# bcd_digit_accumulator

Multi-digit BCD-to-binary stage that sits directly downstream of the per-digit BCD/binary converter. It takes a stream of 4-bit decimal digits, most significant digit first, with a valid/ready handshake and accumulates them as value = value*10 + digit. It presents the finished binary number on a registered output handshake, or an error flag if any digit was not a legal BCD code (1010–1111).

## Interface
- NUM_DIGITS, 3, maximum digits per number (≥1)
- OUT_W, 10, result width; must satisfy 2^OUT_W > 10^NUM_DIGITS − 1 (3 digits → 10 bits)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- digit_in  in  4  BCD digit
- digit_valid  in  1  digit_in is valid this cycle
- digit_last  in  1  qualifies the current digit as the final digit of the number
- digit_ready  out  1  block accepts a digit this cycle
- bin_out  out  OUT_W  accumulated binary result
- bin_err  out  1  result is invalid (illegal digit seen)
- out_valid  out  1  bin_out/bin_err are valid
- out_ready  in  1  downstream consumes the result

## Operation
- Digit transfer occurs when digit_valid && digit_ready; result transfer occurs when out_valid && out_ready.
- States:
  - S_IDLE: ready=1. On transfer, a legal digit loads acc=digit, cnt=1; an illegal digit (>9) goes to S_ERR.
  - S_ACC: ready=1. A legal digit sets acc = acc*10 + digit and cnt++. An illegal digit goes to S_ERR.
  - S_ERR: ready=1. Digits are discarded; cnt still counts.
  - S_DONE: ready=0, out_valid=1. On out_ready, go to S_IDLE.
- Number termination:
  - The number terminates on the transfer where digit_last=1, or where cnt reaches NUM_DIGITS, whichever comes first.
  - From S_IDLE/S_ACC, termination goes to S_DONE with bin_err=0.
  - From S_ERR, termination goes to S_DONE with bin_err=1 and bin_out=0.
  - An illegal digit that is itself the terminating digit goes straight to S_DONE with bin_err=1.
- Arithmetic:
  - acc*10 is computed as (acc<<3)+(acc<<1), plus the zero-extended digit, in OUT_W bits.
  - The parameter constraint guarantees no overflow.
- digit_last with digit_valid=0 is ignored. digit_in is don't-care when not transferred.
- A single-digit number (digit_last on the first digit) is legal: bin_out = digit.

## Timing
- Reset (asynchronous assert, synchronous release on next clk edge):
  - state=S_IDLE, acc=0, cnt=0
  - bin_out=0, bin_err=0, out_valid=0, digit_ready=1 (combinational from state)
- All outputs are registered except digit_ready, which is decoded from state only and has no combinational path from digit_valid.
- Latency: out_valid rises on the clock edge that accepts the terminating digit. The result is visible in the following cycle.
- Throughput: one digit per cycle. A k-digit number occupies k+1 cycles minimum, because S_DONE lasts at least one cycle.
- Back-pressure:
  - While out_ready=0, out_valid, bin_out and bin_err hold stable and digit_ready=0.
  - bin_out/bin_err remain at their last values after the handshake until the next S_DONE.
- Reset mid-number discards acc/cnt immediately. Reset during S_DONE drops out_valid asynchronously.

## Structure
- Shared package bcd_pkg:
  - state enum (S_IDLE, S_ACC, S_ERR, S_DONE)
  - constant BCD_MAX = 4'd9
  - function is_bcd(digit)
- Sub-module mul10_add:
  - combinational block; input acc[OUT_W], digit[4]; output acc*10+digit
  - reusable by other decimal-conversion stages
- Top: state register, acc/cnt registers, output registers. cnt width is $clog2(NUM_DIGITS+1).

## Test plan
- Reset: hold reset=0 for 3 cycles with digit_valid=1 → out_valid=0, bin_out=0, digit_ready=1. No digit accepted until reset=1.
- Full number: digits 9,8,7 back-to-back, last unasserted, out_ready=1 → out_valid one cycle after the '7' transfer, bin_out=987, bin_err=0, digit_ready=0 for exactly that cycle.
- Early termination: digits 4,2 with digit_last on '2' → bin_out=42. A following single digit 5 with digit_last → bin_out=5.
- Illegal digit: digits 1, 4'b1111, 3 → bin_err=1, bin_out=0 after the third transfer. The next number 0,0,1 → bin_out=1, bin_err=0.
- Back-pressure: complete 123 with out_ready=0 for 4 cycles → bin_out=123 held stable, digit_ready=0 throughout. Raise out_ready → return to S_IDLE next cycle.
- Mid-number reset: digits 5,6, then assert reset for 1 cycle, then 7,8,9 → bin_out=789.
